// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data-cache request FSM (IDLE/BUSY/DONE).
// Optional BUSY watchdog with sticky error flag: define MEM_TIMEOUT_EN.
module ex_mem_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RADDR_W     = 5,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [DATA_W-1:0]  ALUResult_i,
  input  logic [DATA_W-1:0]  RS2data_i,
  input  logic [RADDR_W-1:0] RDaddr_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic               RegWrite_i,
  input  logic               MemtoReg_i,
  output logic [DATA_W-1:0]  ALUResult_o,
  output logic [RADDR_W-1:0] RDaddr_o,
  output logic               RegWrite_o,
  output logic               MemtoReg_o,
  output logic [DATA_W-1:0]  MemData_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [DATA_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic               mem_ack_i,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  output logic               cpu_stall_o,
  output logic               mem_err_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    alu_q, alu_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [RADDR_W-1:0]   rd_q, rd_d;
  logic                 regwrite_q, regwrite_d;
  logic                 memtoreg_q, memtoreg_d;
  logic                 memread_q, memread_d;
  logic                 memwrite_q, memwrite_d;
  logic [DATA_W-1:0]    memdata_q, memdata_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic                 load_en;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC >= 256) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Stall comes from a flop, so the register freeze never depends on mem_ack_i combinationally.
  assign load_en = start_i & ~req_q;

  always_comb begin
    state_d    = state_q;
    alu_d      = alu_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memdata_d  = memdata_q;
    err_d      = err_q;

    if (load_en) begin
      alu_d      = ALUResult_i;
      wdata_d    = RS2data_i;
      rd_d       = RDaddr_i;
      regwrite_d = RegWrite_i;
      memtoreg_d = MemtoReg_i;
      memread_d  = MemRead_i;
      memwrite_d = MemWrite_i;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (load_en && (MemRead_i || MemWrite_i)) begin
          state_d = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (mem_ack_i) begin
          state_d = StDone;
          // Read+write together is a store, so only a pure load captures data.
          if (memread_q && !memwrite_q) begin
            memdata_d = mem_rdata_i;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          state_d   = StDone;
          memdata_d = '0;
          err_d     = 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    req_d = (state_d == StBusy);
    we_d  = req_d & memwrite_d;
  end

`ifdef MEM_TIMEOUT_EN
  always_comb begin
    cnt_d = '0;
    if (state_q == StBusy) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      alu_q      <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memdata_q  <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_q      <= alu_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memdata_q  <= memdata_d;
      req_q      <= req_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  assign ALUResult_o = alu_q;
  assign RDaddr_o    = rd_q;
  assign RegWrite_o  = regwrite_q;
  assign MemtoReg_o  = memtoreg_q;
  assign MemData_o   = memdata_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = alu_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_stall_o = req_q;

`ifdef MEM_TIMEOUT_EN
  assign mem_err_o = err_q;
`else
  assign mem_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage; expected load data goes through a scoreboard queue.
module tb_ex_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [31:0] ALUResult_i, RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
  logic [31:0] ALUResult_o;
  logic [4:0]  RDaddr_o;
  logic        RegWrite_o, MemtoReg_o;
  logic [31:0] MemData_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        cpu_stall_o, mem_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  ex_mem_stage #(
    .DATA_W      (32),
    .RADDR_W     (5),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .ALUResult_i (ALUResult_i),
    .RS2data_i   (RS2data_i),
    .RDaddr_i    (RDaddr_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .RegWrite_i  (RegWrite_i),
    .MemtoReg_i  (MemtoReg_i),
    .ALUResult_o (ALUResult_o),
    .RDaddr_o    (RDaddr_o),
    .RegWrite_o  (RegWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .MemData_o   (MemData_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .cpu_stall_o (cpu_stall_o),
    .mem_err_o   (mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic rw, input logic m2r);
    ALUResult_i = alu;
    RS2data_i   = rs2;
    RDaddr_i    = rd;
    MemRead_i   = mr;
    MemWrite_i  = mw;
    RegWrite_i  = rw;
    MemtoReg_i  = m2r;
  endtask

  // Serve one BUSY episode: ack during the ack_after-th stalled cycle (0 = never).
  task automatic run_mem(input int ack_after, input logic [31:0] rdata, input logic [31:0] addr,
                         output int stall_cycles, output int we_cycles);
    stall_cycles = 0;
    we_cycles    = 0;
    for (int i = 0; i < 100; i++) begin
      if (!cpu_stall_o) break;
      stall_cycles++;
      if (mem_we_o) we_cycles++;
      check("busy_req", {31'd0, mem_req_o}, 32'd1);
      check("busy_addr", mem_addr_o, addr);
      @(negedge clk_i);
      if (stall_cycles == ack_after) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
      end
      tick();
      mem_ack_i = 1'b0;
    end
  endtask

  task automatic check_sb(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, MemData_o, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, wc;
    rst_n_i     = 1'b0;
    start_i     = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_alu", ALUResult_o, 32'h0);
    check("rst_memdata", MemData_o, 32'h0);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_stall", {31'd0, cpu_stall_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Plain ALU op
    @(negedge clk_i);
    drive(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    start_i = 1'b1;
    tick();
    check("alu_result", ALUResult_o, 32'h1234);
    check("alu_rd", {27'd0, RDaddr_o}, 32'd5);
    check("alu_regwrite", {31'd0, RegWrite_o}, 32'd1);
    check("alu_req", {31'd0, mem_req_o}, 32'd0);
    check("alu_stall", {31'd0, cpu_stall_o}, 32'd0);
    drive(32'h5555, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    start_i = 1'b0;
    tick();
    check("hold_alu", ALUResult_o, 32'h1234);
    check("hold_rd", {27'd0, RDaddr_o}, 32'd5);

    // Load, ack in the third BUSY cycle; inputs change during the stall
    @(negedge clk_i);
    drive(32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    start_i = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    tick();
    check("ld_stall", {31'd0, cpu_stall_o}, 32'd1);
    check("ld_we", {31'd0, mem_we_o}, 32'd0);
    drive(32'h999, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_mem(3, 32'hDEADBEEF, 32'h100, sc, wc);
    start_i = 1'b0;
    check("ld_stall_cycles", sc, 32'd3);
    check_sb("ld_data");
    check("ld_no_latch", ALUResult_o, 32'h100);
    check("ld_rd", {27'd0, RDaddr_o}, 32'd7);
    check("ld_done_req", {31'd0, mem_req_o}, 32'd0);

    // Store, ack in first BUSY cycle, start dropped while BUSY
    @(negedge clk_i);
    drive(32'h40, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    start_i = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    tick();
    start_i = 1'b0;
    check("st_wdata", mem_wdata_o, 32'hA5A5A5A5);
    run_mem(1, 32'h0BADBAD0, 32'h40, sc, wc);
    check("st_stall_cycles", sc, 32'd1);
    check("st_we_cycles", wc, 32'd1);
    check_sb("st_memdata_kept");
    check("st_done_we", {31'd0, mem_we_o}, 32'd0);

    // Back-to-back loads with a stray ack in DONE
    @(negedge clk_i);
    drive(32'h200, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    start_i = 1'b1;
    exp_q.push_back(32'h11111111);
    tick();
    drive(32'h300, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    run_mem(1, 32'h11111111, 32'h200, sc, wc);
    check("b2b1_stall_cycles", sc, 32'd1);
    check_sb("b2b1_data");
    check("b2b1_addr", ALUResult_o, 32'h200);
    @(negedge clk_i);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0BAD0;
    exp_q.push_back(32'h22222222);
    tick();
    mem_ack_i = 1'b0;
    start_i   = 1'b0;
    check("b2b2_busy", {31'd0, cpu_stall_o}, 32'd1);
    check("b2b2_addr", ALUResult_o, 32'h300);
    check("b2b_stray_ack", MemData_o, 32'h11111111);
    run_mem(2, 32'h22222222, 32'h300, sc, wc);
    check("b2b2_stall_cycles", sc, 32'd2);
    check_sb("b2b2_data");

    // Read and write together behave as a store
    @(negedge clk_i);
    drive(32'h80, 32'h13579BDF, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
    start_i = 1'b1;
    exp_q.push_back(32'h22222222);
    tick();
    start_i = 1'b0;
    run_mem(1, 32'h66666666, 32'h80, sc, wc);
    check("rw_we_cycles", wc, 32'd1);
    check_sb("rw_memdata_kept");

    // Ack while IDLE is ignored
    tick();
    @(negedge clk_i);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h99999999;
    tick();
    mem_ack_i = 1'b0;
    check("idle_ack_stall", {31'd0, cpu_stall_o}, 32'd0);
    check("idle_ack_data", MemData_o, 32'h22222222);

    // Long wait: aborts after 4 cycles with the watchdog, otherwise waits for ack
    @(negedge clk_i);
    drive(32'h500, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
`ifdef MEM_TIMEOUT_EN
    exp_q.push_back(32'h0);
    run_mem(0, 32'h0, 32'h500, sc, wc);
    check("to_stall_cycles", sc, 32'd4);
    check_sb("to_data");
    check("to_err", {31'd0, mem_err_o}, 32'd1);
    @(negedge clk_i);
    drive(32'h77, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("to_err_sticky", {31'd0, mem_err_o}, 32'd1);
    check("to_next_alu", ALUResult_o, 32'h77);
`else
    exp_q.push_back(32'hCAFEF00D);
    run_mem(6, 32'hCAFEF00D, 32'h500, sc, wc);
    check("slow_stall_cycles", sc, 32'd6);
    check_sb("slow_data");
    check("slow_err", {31'd0, mem_err_o}, 32'd0);
`endif

    // Asynchronous reset in the middle of BUSY
    @(negedge clk_i);
    drive(32'h600, 32'hFFFF0000, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("mid_busy", {31'd0, cpu_stall_o}, 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_req", {31'd0, mem_req_o}, 32'd0);
    check("arst_stall", {31'd0, cpu_stall_o}, 32'd0);
    check("arst_we", {31'd0, mem_we_o}, 32'd0);
    check("arst_alu", ALUResult_o, 32'h0);
    check("arst_wdata", mem_wdata_o, 32'h0);
    check("arst_ctl", {28'd0, RDaddr_o == 5'd0, RegWrite_o, MemtoReg_o, mem_err_o}, 32'd8);
    check("arst_memdata", MemData_o, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    tick();
    check("post_rst_stall", {31'd0, cpu_stall_o}, 32'd0);
    check("post_rst_req", {31'd0, mem_req_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
